hermes_pkt_injector: RTL and testbench

//  Packet transmitter for one Hermes router input port; normally the LOCAL port of the NI.

---
 rtl/hermes_pkt_injector.sv | 200 ++++++++++++++++++++
 tb/tb_hermes_pkt_injector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hermes_pkt_injector.sv
// hermes_pkt_injector: single-packet transmitter for one Hermes router input port.
// Sends a header flit (target in the low byte), a size flit, then `size` payload flits.
// Transfers are under credit flow control and only one packet is in flight at a time.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start             launch a packet (sampled only while idle)
//   target, size      header address and payload length, latched at start
//   wr_en, wr_data    payload FIFO write port (writes allowed in any state)
//   fifo_full         registered: payload FIFO holds FIFO_DEPTH entries
//   busy, done        packet in progress / one-cycle pulse after the last flit
//   tx, data_out      flit valid and flit to router rx/data_in
//   credit_i          router has space
// Build option: HERMES_INJ_SEQGEN_EN replaces the FIFO with an internal payload
// sequence 1,2,3,... (wr_en/wr_data ignored, fifo_full tied low).
module hermes_pkt_injector #(
   parameter int unsigned FLIT_W     = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        target,
   input  logic [FLIT_W-1:0] size,
   input  logic              wr_en,
   input  logic [FLIT_W-1:0] wr_data,
   output logic              fifo_full,
   output logic              busy,
   output logic              done,
   output logic              tx,
   output logic [FLIT_W-1:0] data_out,
   input  logic              credit_i
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HEADER  = 2'd1;
   localparam logic [1:0] ST_SIZE    = 2'd2;
   localparam logic [1:0] ST_PAYLOAD = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [FLIT_W-1:0] size_q, size_d;
   logic [FLIT_W-1:0] remaining_q, remaining_d;
   logic [FLIT_W-1:0] data_q, data_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Payload flit that will be presented next cycle, and whether one exists.
   logic [FLIT_W-1:0] head_d;
   logic              avail_d;

   logic xfer;
   assign xfer = tx_q && credit_i;

`ifdef HERMES_INJ_SEQGEN_EN
   // Internal payload sequence: first payload flit is 1, each transfer advances it.
   always_comb begin
      avail_d = 1'b1;
      head_d  = data_q;
      if (state_q == ST_SIZE) begin
         head_d = FLIT_W'(1);
      end else if (xfer) begin
         head_d = data_q + FLIT_W'(1);
      end
   end

   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_data};
   assign fifo_full = 1'b0;
`else
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  cnt_after_pop;
   logic              full_q;
   logic              push, pop;

   // FIFO pointer/count update; head bypasses the write when it lands in an empty FIFO.
   always_comb begin
      push          = wr_en && !full_q;
      pop           = (state_q == ST_PAYLOAD) && xfer;
      rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d      = wr_ptr_q + PTR_W'(push);
      cnt_after_pop = count_q - CNT_W'(pop);
      count_d       = cnt_after_pop + CNT_W'(push);
      avail_d       = (count_d != '0);
      head_d        = (cnt_after_pop == '0) ? wr_data : mem_q[rd_ptr_d];
   end

   // Storage is not reset; occupancy tracking makes stale entries invisible.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // FIFO control registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CNT_W'(FIFO_DEPTH));
      end
   end

   assign fifo_full = full_q;
`endif

   // Next-state and next-output logic; tx/data_out are registered from their next values.
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      remaining_d = remaining_q;
      data_d      = data_q;
      tx_d        = tx_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b0;
            if (start) begin
               size_d  = size;
               data_d  = FLIT_W'(target);
               tx_d    = 1'b1;
               state_d = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (xfer) begin
               data_d  = size_q;
               state_d = ST_SIZE;
            end
         end
         ST_SIZE: begin
            if (xfer) begin
               remaining_d = size_q;
               if (size_q == '0) begin
                  tx_d    = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tx_d    = avail_d;
                  data_d  = avail_d ? head_d : data_q;
                  state_d = ST_PAYLOAD;
               end
            end
         end
         default: begin
            if (xfer && (remaining_q == FLIT_W'(1))) begin
               tx_d    = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               if (xfer) begin
                  remaining_d = remaining_q - FLIT_W'(1);
               end
               // Bubble while the FIFO is empty; picks up new data as soon as it lands.
               tx_d   = avail_d;
               data_d = avail_d ? head_d : data_q;
            end
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         size_q      <= '0;
         remaining_q <= '0;
         data_q      <= '0;
         tx_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         remaining_q <= remaining_d;
         data_q      <= data_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign tx       = tx_q;
   assign data_out = data_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_hermes_pkt_injector.sv
// Testbench for hermes_pkt_injector: table-driven packets, hand-written corner cases and
// a randomized run, all checked cycle by cycle against a packet-level reference model.
module tb_hermes_pkt_injector;

   localparam int unsigned FLIT_W = 16;
   localparam int unsigned DEPTH  = 8;
`ifdef HERMES_INJ_SEQGEN_EN
   localparam bit SEQ = 1'b1;
`else
   localparam bit SEQ = 1'b0;
`endif

   logic              clock    = 1'b0;
   logic              reset    = 1'b1;
   logic              start    = 1'b0;
   logic [7:0]        target   = '0;
   logic [FLIT_W-1:0] size     = '0;
   logic              wr_en    = 1'b0;
   logic [FLIT_W-1:0] wr_data  = '0;
   logic              credit_i = 1'b0;
   logic              fifo_full, busy, done, tx;
   logic [FLIT_W-1:0] data_out;

   hermes_pkt_injector #(.FLIT_W(FLIT_W), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .start(start), .target(target), .size(size),
      .wr_en(wr_en), .wr_data(wr_data), .fifo_full(fifo_full), .busy(busy),
      .done(done), .tx(tx), .data_out(data_out), .credit_i(credit_i)
   );

   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: payload FIFO contents plus packet progress (flits sent so far).
   logic [FLIT_W-1:0] mq[$];
   bit                m_active = 1'b0;
   bit                m_done   = 1'b0;
   int                m_idx    = 0;
   logic [7:0]        m_target = '0;
   logic [FLIT_W-1:0] m_size   = '0;
   int                cyc      = 0;

   typedef struct {
      logic [7:0]        target;
      logic [FLIT_W-1:0] size;
      int                npre;
      logic [FLIT_W-1:0] base;
      int                stall_idx;
      int                stall_len;
      int                exp_cycles;
   } vec_t;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
   endfunction

   function automatic bit exp_tx();
      return m_active && (m_idx < 2 || SEQ || mq.size() != 0);
   endfunction

   function automatic logic [FLIT_W-1:0] exp_data();
      if (m_idx == 0) return FLIT_W'(m_target);
      if (m_idx == 1) return m_size;
      if (SEQ) return FLIT_W'(m_idx - 1);
      return mq[0];
   endfunction

   // Compare outputs of the current cycle, advance the model over the next edge, clock.
   task automatic step();
      bit ntx, xfer, was_active, wr_ok;
      ntx = exp_tx();
      check("tx", 32'(tx), 32'(ntx));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("fifo_full", 32'(fifo_full), 32'(!SEQ && mq.size() == DEPTH));
      if (ntx) check("data_out", 32'(data_out), 32'(exp_data()));
      was_active = m_active;
      xfer       = ntx && credit_i;
      wr_ok      = !SEQ && wr_en && (mq.size() < DEPTH);
      m_done     = 1'b0;
      if (xfer) begin
         if (m_idx >= 2 && !SEQ) void'(mq.pop_front());
         m_idx++;
         if (m_idx == int'(m_size) + 2) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
      if (!was_active && start) begin
         m_active = 1'b1;
         m_idx    = 0;
         m_target = target;
         m_size   = size;
      end
      if (wr_ok) mq.push_back(wr_data);
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic run_to_done(input int budget);
      int n = 0;
      while (!m_done && n < budget) begin
         step();
         n++;
      end
      check("packet_timeout", 32'(m_done), 32'd1);
      step();
   endtask

   task automatic wait_idx(input int idx, input int budget);
      int n = 0;
      while (m_idx < idx && m_active && n < budget) begin
         step();
         n++;
      end
      check("wait_idx_timeout", 32'(m_idx >= idx), 32'd1);
   endtask

   task automatic run_packet(input vec_t v);
      int t0, stalled, n;
      stalled = 0;
      n       = 0;
      credit_i = 1'b1;
      for (int k = 0; k < v.npre; k++) begin
         wr_en   = 1'b1;
         wr_data = v.base + FLIT_W'(k);
         step();
      end
      wr_en  = 1'b0;
      target = v.target;
      size   = v.size;
      start  = 1'b1;
      t0     = cyc;
      step();
      start = 1'b0;
      while (!m_done && n < 200) begin
         credit_i = !(m_active && m_idx == v.stall_idx && stalled < v.stall_len);
         if (!credit_i) stalled++;
         step();
         n++;
      end
      credit_i = 1'b1;
      check("packet_timeout", 32'(m_done), 32'd1);
      check("packet_cycles", 32'(cyc - t0), 32'(v.exp_cycles));
      step();
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{8'h12, 16'd1, 1, 16'h0002, -1, 0, 4};
      tbl[1] = '{8'h12, 16'd1, 1, 16'h0002,  1, 3, 7};
      tbl[2] = '{8'h21, 16'd0, 2, 16'h0050, -1, 0, 3};
      tbl[3] = '{8'h05, 16'd2, 0, 16'h0000, -1, 0, 5};
      tbl[4] = '{8'h33, 16'd4, 4, 16'h0100,  3, 2, 9};
      tbl[5] = '{8'hFF, 16'd7, 7, 16'hA000, -1, 0, 10};

      // Reset state.
      #1;
      check("rst_tx", 32'(tx), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_fifo_full", 32'(fifo_full), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      step();

      foreach (tbl[i]) run_packet(tbl[i]);

`ifndef HERMES_INJ_SEQGEN_EN
      // Payload arrives in pieces after the size flit: bubbles in between.
      credit_i = 1'b1;
      target = 8'h34;
      size   = 16'd3;
      start  = 1'b1;
      step();
      start = 1'b0;
      wait_idx(2, 20);
      step();
      check("bubble_tx_low", 32'(tx), 32'd0);
      for (int k = 0; k < 3; k++) begin
         wr_en   = 1'b1;
         wr_data = FLIT_W'(10 + k);
         step();
         wr_en = 1'b0;
         step();
      end
      run_to_done(20);

      // Overfill in idle: the ninth write is dropped.
      for (int k = 0; k < int'(DEPTH) + 1; k++) begin
         wr_en   = 1'b1;
         wr_data = FLIT_W'(16'h0C00 + k);
         step();
         if (k == int'(DEPTH) - 1) check("full_after_depth", 32'(fifo_full), 32'd1);
      end
      wr_en = 1'b0;
`endif
      run_packet('{8'h77, 16'd8, 0, 16'h0000, -1, 0, 11});

      // Reset in the middle of the payload.
      run_packet('{8'h40, 16'd0, 3, 16'h0200, -1, 0, 3});
      target = 8'h41;
      size   = 16'd3;
      start  = 1'b1;
      step();
      start = 1'b0;
      wait_idx(3, 20);
      reset = 1'b1;
      #1;
      check("async_reset_tx", 32'(tx), 32'd0);
      check("async_reset_busy", 32'(busy), 32'd0);
      mq.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_idx    = 0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      step();
      // After reset the FIFO is empty (default) or the sequence restarts at 1.
      target = 8'h42;
      size   = 16'd3;
      start  = 1'b1;
      step();
      start = 1'b0;
      wait_idx(2, 20);
      repeat (2) step();
      wr_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wr_data = FLIT_W'(16'h0300 + k);
         step();
      end
      wr_en = 1'b0;
      run_to_done(20);

      // Randomized traffic: starts while busy, mid-packet input changes, credit stalls.
      repeat (1500) begin
         start    = ($urandom % 4) == 0;
         target   = 8'($urandom);
         size     = FLIT_W'($urandom_range(0, 5));
         wr_en    = ($urandom % 2) == 0;
         wr_data  = FLIT_W'($urandom);
         credit_i = ($urandom % 4) != 0;
         step();
      end
      start = 1'b0;
      begin
         int n = 0;
         while (m_active && n < 200) begin
            wr_en    = 1'b1;
            wr_data  = FLIT_W'($urandom);
            credit_i = 1'b1;
            step();
            n++;
         end
         check("drain_timeout", 32'(m_active), 32'd0);
      end
      wr_en = 1'b0;
      repeat (2) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
